// File: rtl/sync_nff_filt.sv
`default_nettype none
// ============================================================================
//  Module   : sync_nff_filt
//  Brief    : WIDTH-channel, STAGES-deep level synchroniser into the clk
//             domain, with an optional per-channel stability filter
//             (FILTER consecutive mismatching cycles before dout_sync moves)
//             and a programmable reset value.
//  Optional : `define SYNC_EDGE_DET_EN builds per-channel rise/fall pulse
//             outputs; without it rise_pls/fall_pls are tied to zero.
//  Ports    : clk        - destination clock
//             rst_n      - synchronous active-low reset
//             din_async  - [WIDTH] level inputs from foreign domain(s)
//             dout_sync  - [WIDTH] synchronised (and filtered) levels
//             rise_pls   - [WIDTH] 1-cycle pulse on dout_sync 0->1
//             fall_pls   - [WIDTH] 1-cycle pulse on dout_sync 1->0
//  Revision : 1.0 - initial release
// ============================================================================
module sync_nff_filt #(
    parameter int               WIDTH   = 4,
    parameter int               STAGES  = 2,
    parameter int               FILTER  = 0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_async,
    output logic [WIDTH-1:0] dout_sync,
    output logic [WIDTH-1:0] rise_pls,
    output logic [WIDTH-1:0] fall_pls
);

    // ------------------------------------------------------------------------
    // Parameter sanity
    // ------------------------------------------------------------------------
    if (STAGES < 2) begin : g_bad_stages
        $error("sync_nff_filt: STAGES must be >= 2");
    end

    // ------------------------------------------------------------------------
    // Synchroniser chain. Pure flop-to-flop; stage 0 only feeds stage 1 so
    // the metastability window gets the full clock period to resolve.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_stage [STAGES];
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_dout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stage[k] <= RST_VAL;
            end
        end else begin
            r_stage[0] <= din_async;
            for (int k = 1; k < STAGES; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign w_sync = r_stage[STAGES-1];

    // ------------------------------------------------------------------------
    // Stability filter
    // ------------------------------------------------------------------------
    if (FILTER == 0) begin : g_no_filter
        assign w_dout = w_sync;
    end else begin : g_filter
        localparam int c_CNT_W = $clog2(FILTER + 1);
        localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FILTER - 1);
        localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            logic [c_CNT_W-1:0] r_cnt;
            logic               r_bit;

            // The counter tracks how many consecutive cycles the synchronised
            // level has disagreed with the output. Any agreement clears it,
            // so a glitch shorter than FILTER cycles leaves no trace. The
            // counter saturates at FILTER-1 by construction: reaching it
            // while still mismatched commits the new level and clears.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                    r_bit <= RST_VAL[i];
                end else if (w_sync[i] == r_bit) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    r_bit <= w_sync[i];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end

            assign w_dout[i] = r_bit;
        end
    end

    assign dout_sync = w_dout;

    // ------------------------------------------------------------------------
    // Edge pulses. The history register resets to RST_VAL together with the
    // output, so entering or leaving reset never produces a pulse.
    // ------------------------------------------------------------------------
`ifdef SYNC_EDGE_DET_EN
    logic [WIDTH-1:0] r_dout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dout_q <= RST_VAL;
        end else begin
            r_dout_q <= w_dout;
        end
    end

    assign rise_pls = w_dout & ~r_dout_q;
    assign fall_pls = ~w_dout & r_dout_q;
`else
    assign rise_pls = '0;
    assign fall_pls = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_nff_filt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_nff_filt
//  Brief    : Directed self-checking bench for sync_nff_filt. Four instances
//             cover reset value, chain latency, filter pass / glitch reject /
//             reset mid-count, and edge pulses. Pulse expectations follow
//             SYNC_EDGE_DET_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sync_nff_filt;

`ifdef SYNC_EDGE_DET_EN
    localparam bit c_EDGE_EN = 1'b1;
`else
    localparam bit c_EDGE_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] din_a, din_b, din_c, din_d;
    logic [3:0] dout_a, rise_a, fall_a;
    logic [3:0] dout_b, rise_b, fall_b;
    logic [3:0] dout_c, rise_c, fall_c;
    logic [3:0] dout_d, rise_d, fall_d;

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset-value instance
    sync_nff_filt #(.WIDTH(4), .STAGES(2), .FILTER(0), .RST_VAL(4'b1010)) u_a (
        .clk(clk), .rst_n(rst_n), .din_async(din_a),
        .dout_sync(dout_a), .rise_pls(rise_a), .fall_pls(fall_a));

    // Latency instance
    sync_nff_filt #(.WIDTH(4), .STAGES(3), .FILTER(0), .RST_VAL(4'b0000)) u_b (
        .clk(clk), .rst_n(rst_n), .din_async(din_b),
        .dout_sync(dout_b), .rise_pls(rise_b), .fall_pls(fall_b));

    // Filter instance
    sync_nff_filt #(.WIDTH(4), .STAGES(2), .FILTER(4), .RST_VAL(4'b0000)) u_c (
        .clk(clk), .rst_n(rst_n), .din_async(din_c),
        .dout_sync(dout_c), .rise_pls(rise_c), .fall_pls(fall_c));

    // Edge instance
    sync_nff_filt #(.WIDTH(4), .STAGES(2), .FILTER(0), .RST_VAL(4'b0000)) u_d (
        .clk(clk), .rst_n(rst_n), .din_async(din_d),
        .dout_sync(dout_d), .rise_pls(rise_d), .fall_pls(fall_d));

    // Advance past one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        din_a = 4'hF;
        do_reset();
        checks++;
        if (dout_a !== 4'b1010) begin
            errors++;
            $display("FAIL reset_dout: got %b expected %b", dout_a, 4'b1010);
        end
        checks++;
        if ({rise_a, fall_a} !== 8'h00) begin
            errors++;
            $display("FAIL reset_pulses: got rise %b fall %b expected 0", rise_a, fall_a);
        end
        tick();
        checks++;
        if (dout_a !== 4'b1010) begin
            errors++;
            $display("FAIL release_e1_dout: got %b expected %b", dout_a, 4'b1010);
        end
        tick();
        checks++;
        if (dout_a !== 4'hF) begin
            errors++;
            $display("FAIL release_e2_dout: got %b expected %b", dout_a, 4'hF);
        end
        checks++;
        if (rise_a !== (c_EDGE_EN ? 4'b0101 : 4'b0000) || fall_a !== 4'b0000) begin
            errors++;
            $display("FAIL release_e2_pulses: got rise %b fall %b expected rise %b fall 0000",
                     rise_a, fall_a, c_EDGE_EN ? 4'b0101 : 4'b0000);
        end
    endtask

    task automatic test_latency();
        logic [4:0] tbl_dout;
        logic [4:0] tbl_rise;
        tbl_dout = 5'b11100;  // bit k-1 = dout[0] after tick k
        tbl_rise = 5'b00100;
        din_b = 4'b0000;
        do_reset();
        din_b = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (dout_b !== {3'b000, tbl_dout[k-1]}) begin
                errors++;
                $display("FAIL latency_dout tick %0d: got %b expected %b", k, dout_b,
                         {3'b000, tbl_dout[k-1]});
            end
            checks++;
            if (rise_b !== {3'b000, tbl_rise[k-1] & c_EDGE_EN} || fall_b !== 4'b0000) begin
                errors++;
                $display("FAIL latency_pulse tick %0d: got rise %b fall %b expected rise %b",
                         k, rise_b, fall_b, {3'b000, tbl_rise[k-1] & c_EDGE_EN});
            end
        end
    endtask

    task automatic test_filter_pass();
        logic [6:0] tbl_dout;
        tbl_dout = 7'b1100000;  // bit k-1 = dout[1] after tick k
        din_c = 4'b0000;
        do_reset();
        din_c = 4'b0010;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if (dout_c !== {2'b00, tbl_dout[k-1], 1'b0}) begin
                errors++;
                $display("FAIL filter_pass tick %0d: got %b expected %b", k, dout_c,
                         {2'b00, tbl_dout[k-1], 1'b0});
            end
            if (k == 6 || k == 7) begin
                checks++;
                if (rise_c !== ((k == 6 && c_EDGE_EN) ? 4'b0010 : 4'b0000)) begin
                    errors++;
                    $display("FAIL filter_pass_rise tick %0d: got %b", k, rise_c);
                end
            end
        end
    endtask

    task automatic test_glitch_reject();
        din_c = 4'b0000;
        do_reset();
        din_c = 4'b0100;
        tick();
        tick();
        tick();
        din_c = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (dout_c !== 4'b0000 || rise_c !== 4'b0000) begin
                errors++;
                $display("FAIL glitch_hold tick %0d: got dout %b rise %b expected 0000/0000",
                         k, dout_c, rise_c);
            end
        end
        // A fresh stable level must take the full latency: counter was cleared.
        din_c = 4'b0100;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (dout_c !== ((k == 6) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL glitch_after tick %0d: got %b expected %b", k, dout_c,
                         (k == 6) ? 4'b0100 : 4'b0000);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        din_c = 4'b0000;
        do_reset();
        din_c = 4'b0001;
        for (int k = 1; k <= 6; k++) tick();
        checks++;
        if (dout_c !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_setup: got %b expected %b", dout_c, 4'b0001);
        end
        din_c = 4'b0000;
        for (int k = 1; k <= 4; k++) tick();  // fall count now at 2
        checks++;
        if (dout_c !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_counting: got %b expected %b", dout_c, 4'b0001);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (dout_c !== 4'b0000 || rise_c !== 4'b0000 || fall_c !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_reset: got dout %b rise %b fall %b expected 0000/0000/0000",
                     dout_c, rise_c, fall_c);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (dout_c !== 4'b0000 || rise_c !== 4'b0000 || fall_c !== 4'b0000) begin
                errors++;
                $display("FAIL midrst_after tick %0d: got dout %b rise %b fall %b", k,
                         dout_c, rise_c, fall_c);
            end
        end
    endtask

    task automatic test_edges();
        din_d = 4'b0000;
        do_reset();
        din_d = 4'b0101;
        tick();
        tick();
        checks++;
        if (dout_d !== 4'b0101 || rise_d !== (c_EDGE_EN ? 4'b0101 : 4'b0000)) begin
            errors++;
            $display("FAIL edges_first: got dout %b rise %b", dout_d, rise_d);
        end
        tick();
        din_d = 4'b1010;
        tick();
        checks++;
        if (dout_d !== 4'b0101 || rise_d !== 4'b0000 || fall_d !== 4'b0000) begin
            errors++;
            $display("FAIL edges_pre: got dout %b rise %b fall %b", dout_d, rise_d, fall_d);
        end
        tick();
        checks++;
        if (dout_d !== 4'b1010) begin
            errors++;
            $display("FAIL edges_dout: got %b expected %b", dout_d, 4'b1010);
        end
        checks++;
        if (rise_d !== (c_EDGE_EN ? 4'b1010 : 4'b0000) ||
            fall_d !== (c_EDGE_EN ? 4'b0101 : 4'b0000)) begin
            errors++;
            $display("FAIL edges_pulses: got rise %b fall %b", rise_d, fall_d);
        end
        tick();
        checks++;
        if (rise_d !== 4'b0000 || fall_d !== 4'b0000) begin
            errors++;
            $display("FAIL edges_one_cycle: got rise %b fall %b expected 0000/0000", rise_d, fall_d);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] tbl_dout;
        logic [5:0] tbl_rise;
        logic [5:0] tbl_fall;
        tbl_dout = 6'b101010;
        tbl_rise = 6'b101010;
        tbl_fall = 6'b010100;
        for (int k = 0; k < 6; k++) begin
            din_d = {3'b101, ~k[0]};
            tick();
            checks++;
            if (dout_d !== {3'b101, tbl_dout[k]}) begin
                errors++;
                $display("FAIL b2b_dout step %0d: got %b expected %b", k, dout_d,
                         {3'b101, tbl_dout[k]});
            end
            checks++;
            if (rise_d !== {3'b000, tbl_rise[k] & c_EDGE_EN} ||
                fall_d !== {3'b000, tbl_fall[k] & c_EDGE_EN}) begin
                errors++;
                $display("FAIL b2b_pulses step %0d: got rise %b fall %b expected rise %b fall %b",
                         k, rise_d, fall_d, {3'b000, tbl_rise[k] & c_EDGE_EN},
                         {3'b000, tbl_fall[k] & c_EDGE_EN});
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        din_a  = '0;
        din_b  = '0;
        din_c  = '0;
        din_d  = '0;
        test_reset();
        test_latency();
        test_filter_pass();
        test_glitch_reject();
        test_reset_mid_count();
        test_edges();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
